// File: rtl/hilo_div.sv
// hilo_div: multi-cycle radix-2 restoring divider for DIV/DIVU.
// result_o = {remainder, quotient}; ready_o pulses for one cycle when valid.
// Optional macro HILO_DIV_ZERO_FAST_EN: when defined, a zero divisor takes a
// two-cycle DIV_ZERO path instead of running the full iteration count.
module hilo_div #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start_i,
   input  logic               signed_i,
   input  logic               annul_i,
   input  logic [WIDTH-1:0]   opdata1_i,
   input  logic [WIDTH-1:0]   opdata2_i,
   output logic [2*WIDTH-1:0] result_o,
   output logic               ready_o,
   output logic               busy_o
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DIV_ON   = 2'd1,
`ifdef HILO_DIV_ZERO_FAST_EN
      DIV_ZERO = 2'd2,
`endif
      DIV_END  = 2'd3
   } state_t;

   state_t             r_state;
   state_t             w_next;

   logic [WIDTH-1:0]   r_op1;       // raw dividend, needed for sign fix and zero result
   logic               r_op2_msb;
   logic               r_sign;
   logic               r_dzero;
   logic [WIDTH-1:0]   r_dsr;       // divisor magnitude
   logic [WIDTH-1:0]   r_rem;       // partial remainder
   logic [WIDTH-1:0]   r_quot;      // dividend bits shift out as quotient bits shift in
   logic [CW-1:0]      r_cnt;
   logic [2*WIDTH-1:0] r_result;
   logic               r_ready;
   logic               r_busy;

   logic               w_accept;
   logic               w_last;
   logic               w_op2_zero;
   logic [WIDTH-1:0]   w_mag1;
   logic [WIDTH-1:0]   w_mag2;
   logic [WIDTH:0]     w_shift;
   logic [WIDTH:0]     w_trial;
   logic [WIDTH-1:0]   w_rem_nxt;
   logic [WIDTH-1:0]   w_quot_nxt;
   logic               w_neg_q;
   logic               w_neg_r;
   logic [2*WIDTH-1:0] w_final;

   assign w_accept   = (r_state == IDLE) && start_i && !annul_i;
   assign w_last     = (r_cnt == CW'(WIDTH-1));
   assign w_op2_zero = (opdata2_i == '0);

   // 0x80..0 negates to itself, which is the correct unsigned magnitude
   assign w_mag1 = (signed_i && opdata1_i[WIDTH-1]) ? ('0 - opdata1_i) : opdata1_i;
   assign w_mag2 = (signed_i && opdata2_i[WIDTH-1]) ? ('0 - opdata2_i) : opdata2_i;

   // one restoring step: a negative trial difference shows up in bit WIDTH
   assign w_shift    = {r_rem, r_quot[WIDTH-1]};
   assign w_trial    = w_shift - {1'b0, r_dsr};
   assign w_rem_nxt  = w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
   assign w_quot_nxt = {r_quot[WIDTH-2:0], ~w_trial[WIDTH]};

   assign w_neg_q = r_sign & (r_op1[WIDTH-1] ^ r_op2_msb);
   assign w_neg_r = r_sign & r_op1[WIDTH-1];

   // zero divisor without the fast path still iterates, then the result is forced
   assign w_final = r_dzero ? {r_op1, {WIDTH{1'b1}}}
                            : {(w_neg_r ? ('0 - w_rem_nxt)  : w_rem_nxt),
                               (w_neg_q ? ('0 - w_quot_nxt) : w_quot_nxt)};

   // next-state decode
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
`ifdef HILO_DIV_ZERO_FAST_EN
               w_next = w_op2_zero ? DIV_ZERO : DIV_ON;
`else
               w_next = DIV_ON;
`endif
            end
         end
         DIV_ON: begin
            if (annul_i)     w_next = IDLE;
            else if (w_last) w_next = DIV_END;
         end
`ifdef HILO_DIV_ZERO_FAST_EN
         DIV_ZERO: begin
            w_next = annul_i ? IDLE : DIV_END;
         end
`endif
         DIV_END: w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // state register with ready/busy registered from the next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_ready <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_ready <= (w_next == DIV_END);
`ifdef HILO_DIV_ZERO_FAST_EN
         r_busy  <= (w_next == DIV_ON) || (w_next == DIV_ZERO);
`else
         r_busy  <= (w_next == DIV_ON);
`endif
      end
   end

   // operand capture, iteration datapath and result register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op1     <= '0;
         r_op2_msb <= 1'b0;
         r_sign    <= 1'b0;
         r_dzero   <= 1'b0;
         r_dsr     <= '0;
         r_rem     <= '0;
         r_quot    <= '0;
         r_cnt     <= '0;
         r_result  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_op1     <= opdata1_i;
                  r_op2_msb <= opdata2_i[WIDTH-1];
                  r_sign    <= signed_i;
                  r_dzero   <= w_op2_zero;
                  r_dsr     <= w_mag2;
                  r_quot    <= w_mag1;
                  r_rem     <= '0;
                  r_cnt     <= '0;
               end
            end
            DIV_ON: begin
               if (!annul_i) begin
                  r_rem  <= w_rem_nxt;
                  r_quot <= w_quot_nxt;
                  r_cnt  <= r_cnt + 1'b1;
                  if (w_last) r_result <= w_final;
               end
            end
`ifdef HILO_DIV_ZERO_FAST_EN
            DIV_ZERO: begin
               if (!annul_i) r_result <= {r_op1, {WIDTH{1'b1}}};
            end
`endif
            default: ;
         endcase
      end
   end

   assign result_o = r_result;
   assign ready_o  = r_ready;
   assign busy_o   = r_busy;

endmodule

// File: tb/tb_hilo_div.sv
// Directed testbench for hilo_div with hand-computed expected results.
module tb_hilo_div;

   logic        clk;
   logic        rst_n;
   logic        start_i;
   logic        signed_i;
   logic        annul_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic [63:0] result_o;
   logic        ready_o;
   logic        busy_o;

   int n_checks = 0;
   int n_fail   = 0;

`ifdef HILO_DIV_ZERO_FAST_EN
   localparam int ZLAT = 2;
`else
   localparam int ZLAT = 33;
`endif

   hilo_div #(.WIDTH(32)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start_i   (start_i),
      .signed_i  (signed_i),
      .annul_i   (annul_i),
      .opdata1_i (opdata1_i),
      .opdata2_i (opdata2_i),
      .result_o  (result_o),
      .ready_o   (ready_o),
      .busy_o    (busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Issue one divide at the current cycle T, then watch until ready_o (bounded).
   task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sg, input logic [63:0] exp_res, input int exp_lat);
      int lat;
      int nbusy;
      lat   = 0;
      nbusy = 0;
      opdata1_i = a;
      opdata2_i = b;
      signed_i  = sg;
      start_i   = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
      for (int n = 1; n <= 45 && lat == 0; n++) begin
         if (busy_o) nbusy++;
         if (ready_o) lat = n;
         else begin
            @(posedge clk); #1;
         end
      end
      check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      check({tag, "_res"}, result_o, exp_res);
      check({tag, "_busy"}, 64'(nbusy), 64'(exp_lat - 1));
      @(posedge clk); #1;
   endtask

   initial begin
      int nready;
      int r1;
      int r2;
      logic [63:0] res1;
      logic [63:0] res2;

      rst_n     = 1'b0;
      start_i   = 1'b0;
      signed_i  = 1'b0;
      annul_i   = 1'b0;
      opdata1_i = '0;
      opdata2_i = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_result", result_o, 64'h0);
      check("rst_ready", 64'(ready_o), 64'h0);
      check("rst_busy", 64'(busy_o), 64'h0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      do_div("divu_100_7", 32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 33);
      do_div("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
      do_div("div_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0, 32'h8000_0000}, 33);
      do_div("divu_min_1", 32'h8000_0000, 32'h1, 1'b0, {32'h0, 32'h8000_0000}, 33);
      do_div("divu_zero", 32'h0000_1234, 32'h0, 1'b0, {32'h0000_1234, 32'hFFFF_FFFF}, ZLAT);

      // annul mid-divide: no ready, result unchanged, back to idle
      opdata1_i = 32'd50;
      opdata2_i = 32'd5;
      signed_i  = 1'b0;
      start_i   = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
      repeat (9) begin
         @(posedge clk); #1;
      end
      annul_i = 1'b1;
      @(posedge clk); #1;
      annul_i = 1'b0;
      check("annul_busy", 64'(busy_o), 64'h0);
      check("annul_ready", 64'(ready_o), 64'h0);
      check("annul_result", result_o, {32'h0000_1234, 32'hFFFF_FFFF});
      nready = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (ready_o) nready++;
      end
      check("annul_no_ready", 64'(nready), 64'h0);
      do_div("divu_9_4", 32'd9, 32'd4, 1'b0, {32'd1, 32'd2}, 33);

      // asynchronous reset in the middle of a divide
      opdata1_i = 32'd100;
      opdata2_i = 32'd7;
      start_i   = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
      repeat (14) begin
         @(posedge clk); #1;
      end
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_result", result_o, 64'h0);
      check("mid_rst_ready", 64'(ready_o), 64'h0);
      check("mid_rst_busy", 64'(busy_o), 64'h0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      do_div("post_rst", 32'hFFFF_FFFF, 32'h10, 1'b0, {32'hF, 32'h0FFF_FFFF}, 33);

      // back-to-back signed divides with start_i held high; operands change
      // after the first acceptance and must be picked up only by the second
      opdata1_i = 32'hFFFF_FF9C;   // -100
      opdata2_i = 32'd7;
      signed_i  = 1'b1;
      start_i   = 1'b1;
      @(posedge clk); #1;
      opdata1_i = 32'd1000;
      opdata2_i = 32'hFFFF_FFFD;   // -3
      nready = 0;
      r1 = 0;
      r2 = 0;
      res1 = '0;
      res2 = '0;
      for (int n = 1; n <= 75; n++) begin
         if (n == 35) start_i = 1'b0;
         if (ready_o) begin
            nready++;
            if (r1 == 0) begin
               r1 = n;
               res1 = result_o;
            end else if (r2 == 0) begin
               r2 = n;
               res2 = result_o;
            end
         end
         @(posedge clk); #1;
      end
      start_i = 1'b0;
      check("b2b_first_lat", 64'(r1), 64'd33);
      check("b2b_gap", 64'(r2 - r1), 64'd34);
      check("b2b_count", 64'(nready), 64'd2);
      check("b2b_res1", res1, {32'hFFFF_FFFE, 32'hFFFF_FFF2});
      check("b2b_res2", res2, {32'h0000_0001, 32'hFFFF_FEB3});

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/hilo_div.md
# hilo_div

Multi-cycle 32-bit integer divider answering the decoder's DIV/DIVU requests from the EX stage. It consumes the `start`, `signed` and `annul` strobes. It produces a 64-bit {remainder, quotient} pair for the HI/LO write path when the decoder selects the divider as source (`DataToHI`/`DataToLO` = 2'b10). The pipeline stalls EX while `start_i & ~ready_o`.

## Interface
Parameters:
- `WIDTH`, 32: operand width. Result is 2*WIDTH. Iteration count equals WIDTH.

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `start_i`  in  1  divide request (decoder `startDiv`). Held high by the stalled EX instruction.
- `signed_i`  in  1  1 = DIV (signed), 0 = DIVU (decoder `Sign`). Sampled with `start_i`.
- `annul_i`  in  1  cancel the in-flight divide (decoder `annul` / flush)
- `opdata1_i`  in  WIDTH  dividend (rs). Sampled with `start_i`.
- `opdata2_i`  in  WIDTH  divisor (rt). Sampled with `start_i`.
- `result_o`  out  2*WIDTH  [63:32] remainder → HI, [31:0] quotient → LO
- `ready_o`  out  1  one-cycle pulse: `result_o` valid
- `busy_o`  out  1  divide in progress (DIV_ON or DIV_ZERO)

## Operation
- States: IDLE, DIV_ON, DIV_ZERO, DIV_END.
- IDLE:
  - If `start_i & ~annul_i` and divisor ≠ 0: latch operands and `signed_i`, load magnitudes, clear counter, go to DIV_ON.
  - If `start_i & ~annul_i` and divisor = 0: go to DIV_ZERO.
  - If `annul_i` is high together with `start_i`, the request is not accepted.
- Magnitudes: when signed, `|x|` is the two's complement negation if the MSB is set. 0x80000000 stays 0x80000000 as an unsigned value.
- DIV_ON: radix-2 restoring division, one quotient bit per cycle, MSB first.
  - Shift the partial remainder left by one, bringing in the next dividend bit.
  - Compute a WIDTH+1-bit trial subtraction of the divisor magnitude.
  - If non-negative, keep the difference and set the quotient bit to 1. Otherwise restore and set it to 0.
  - After WIDTH iterations go to DIV_END.
- Sign fix (signed only):
  - Negate the quotient if the operand signs differ.
  - Negate the remainder if the dividend is negative.
  - 0x80000000 / 0xFFFFFFFF yields quotient 0x80000000, remainder 0.
- DIV_ZERO: result forced to quotient = all ones, remainder = raw `opdata1` (both modes), then go to DIV_END.
- DIV_END: `ready_o` = 1 and `result_o` updated for exactly one cycle. Next state is IDLE unconditionally.
- `annul_i` in DIV_ON or DIV_ZERO: go to IDLE next edge. No `ready_o`. `result_o` keeps its previous value.
- `annul_i` in DIV_END: ignored. The pulse still completes.
- `start_i` while DIV_ON: ignored. Operands are not re-sampled.
- `result_o` holds its last value until the next DIV_END.

## Timing
- Reset (async, `rst_n` low): state IDLE, `result_o` = 0, `ready_o` = 0, `busy_o` = 0, counter = 0. Reset mid-divide discards the operation.
- Latency, with T = the cycle in which `start_i` is sampled high in IDLE:
  - Normal divide: `busy_o` high T+1..T+32, `ready_o` high at T+33.
  - Zero divisor (fast path): `busy_o` high at T+1, `ready_o` high at T+2.
- Back-to-back divides: a new `start_i` sampled in the IDLE cycle after DIV_END (T+34) begins the next divide. There is no dead cycle beyond that.
- `ready_o` and `busy_o` are registered, driven from state.

## Configuration
- `HILO_DIV_ZERO_FAST_EN`:
  - Defined: zero divisor takes the DIV_ZERO path, `ready_o` at T+2.
  - Undefined: no DIV_ZERO state. A zero divisor runs the full WIDTH iterations (`ready_o` at T+33) and produces the same forced result (quotient all ones, remainder = raw dividend).

## Test plan
- DIVU 100 / 7, start at T → `ready_o` at T+33, `result_o` = {32'd2, 32'd14}. `busy_o` high T+1..T+32.
- DIV −7 / 2 (0xFFFFFFF9 / 2) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0.
- DIVU 0x1234 / 0 → quotient 0xFFFFFFFF, remainder 0x1234. `ready_o` at T+2 with the macro, T+33 without.
- DIVU 50/5, `annul_i` pulsed at T+10 → state IDLE at T+11, `busy_o` 0, no `ready_o`, `result_o` unchanged. Then DIVU 9/4 → {1, 2} at 33 cycles after its start.
- `rst_n` low at T+15 of a divide → all outputs 0 immediately. After release, `start_i` → normal completion.
- Two back-to-back DIV ops with `start_i` held high → two `ready_o` pulses 34 cycles apart, each with the correct result.
